// File: rtl/elastic_config_pkg.sv
// Shared types for the PE configuration loader: packed context-word layout, loader states
// and the raw-word unpack helper.
package elastic_config_pkg;

  localparam int INPUT_NUM_BIT_LENGTH    = 3;
  localparam int NEIGHBOR_PE_NUM         = 4;
  localparam int OPERATION_BIT_LENGTH    = 4;
  localparam int DATA_WIDTH              = 32;
  localparam int DEFAULT_CONTEXT_SIZE    = 8;
  localparam int CONTEXT_SIZE_BIT_LENGTH = $clog2(DEFAULT_CONTEXT_SIZE);
  localparam int CFG_WORD_WIDTH          = 2 * INPUT_NUM_BIT_LENGTH + NEIGHBOR_PE_NUM
                                         + OPERATION_BIT_LENGTH + DATA_WIDTH;

  // Declared MSB first so that in1 occupies the least significant bits of the memory word.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]           const_data;
    logic [OPERATION_BIT_LENGTH-1:0] op;
    logic [NEIGHBOR_PE_NUM-1:0]      output_mask;
    logic [INPUT_NUM_BIT_LENGTH-1:0] in2;
    logic [INPUT_NUM_BIT_LENGTH-1:0] in1;
  } ElasticConfigWord;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_START} loader_state_e;

  function automatic ElasticConfigWord unpack_config_word(input logic [CFG_WORD_WIDTH-1:0] raw);
    return ElasticConfigWord'(raw);
  endfunction

endpackage

// File: rtl/elastic_config_checksum.sv
// XOR accumulator over configuration words; clear takes priority over enable.
module elastic_config_checksum #(
  parameter int WIDTH = 46
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_sum
);

  logic [WIDTH-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_sum <= '0;
    end else if (i_enable) begin
      r_sum <= r_sum ^ i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/elastic_config_loader.sv
// Streams packed context words from config memory into the PE array, then pulses start_exec.
// Optional XOR integrity check over the streamed words: ELASTIC_CONFIG_LOADER_CHECKSUM_EN.
module elastic_config_loader
  import elastic_config_pkg::*;
#(
  parameter int PE_NUM         = 16,
  parameter int CONTEXT_SIZE   = DEFAULT_CONTEXT_SIZE,
  parameter int CFG_ADDR_WIDTH = 16,
  localparam int CTX_W         = (CONTEXT_SIZE > 1) ? $clog2(CONTEXT_SIZE) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load_start,
  input  logic [CFG_ADDR_WIDTH-1:0]       load_base_address,
  input  logic [CTX_W-1:0]                load_context_max_id,
  output logic                            load_busy,
  output logic                            load_done,
  output logic                            cfg_mem_read,
  output logic [CFG_ADDR_WIDTH-1:0]       cfg_mem_address,
  input  logic [CFG_WORD_WIDTH-1:0]       cfg_mem_data,
  output logic [PE_NUM-1:0]               config_pe_write,
  output logic [CTX_W-1:0]                config_index,
  output logic [INPUT_NUM_BIT_LENGTH-1:0] config_input_PE_index_1,
  output logic [INPUT_NUM_BIT_LENGTH-1:0] config_input_PE_index_2,
  output logic [NEIGHBOR_PE_NUM-1:0]      config_output_PE_index,
  output logic [OPERATION_BIT_LENGTH-1:0] config_op,
  output logic [DATA_WIDTH-1:0]           config_const_data,
  output logic                            start_exec,
  output logic [CTX_W-1:0]                mapping_context_max_id
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
  ,
  input  logic [CFG_WORD_WIDTH-1:0]       load_expected_checksum,
  output logic                            load_error
`endif
);

  localparam int PE_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
  localparam logic [CTX_W-1:0] CTX_LAST = CTX_W'(CONTEXT_SIZE - 1);
  localparam logic [PE_W-1:0]  PE_LAST  = PE_W'(PE_NUM - 1);

  loader_state_e    r_state;
  logic [CTX_W-1:0] r_max_id;
  logic [CTX_W-1:0] r_ctx;
  logic [PE_W-1:0]  r_pe;
  logic             r_read_d;
  logic [CTX_W-1:0] r_ctx_d;
  logic [PE_W-1:0]  r_pe_d;

  logic             w_accept;
  logic             w_last_read;
  logic             w_finish;
  logic             w_sum_ok;
  logic [CTX_W-1:0] w_max_clamped;
  ElasticConfigWord w_word;

  assign w_accept      = (r_state == ST_IDLE) && load_start;
  assign w_last_read   = (r_pe == PE_LAST) && (r_ctx == r_max_id);
  // The last write is on the outputs once no read is left in the return stage.
  assign w_finish      = (r_state == ST_DRAIN) && !r_read_d;
  assign w_max_clamped = (load_context_max_id > CTX_LAST) ? CTX_LAST : load_context_max_id;
  assign w_word        = unpack_config_word(cfg_mem_data);

`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
  logic [CFG_WORD_WIDTH-1:0] r_expected;
  logic [CFG_WORD_WIDTH-1:0] w_sum;

  elastic_config_checksum #(.WIDTH(CFG_WORD_WIDTH)) u_checksum (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_accept),
    .i_enable (r_read_d),
    .i_data   (cfg_mem_data),
    .o_sum    (w_sum)
  );

  assign w_sum_ok = (w_sum == r_expected);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_expected <= '0;
      load_error <= 1'b0;
    end else if (w_accept) begin
      r_expected <= load_expected_checksum;
      load_error <= 1'b0;
    end else if (w_finish) begin
      load_error <= !w_sum_ok;
    end
  end
`else
  assign w_sum_ok = 1'b1;
`endif

  // NOTE: reset is sampled on the clock edge, and every state element uses non-blocking
  // assignment so all registers see the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state                 <= ST_IDLE;
      r_max_id                <= '0;
      r_ctx                   <= '0;
      r_pe                    <= '0;
      r_read_d                <= 1'b0;
      r_ctx_d                 <= '0;
      r_pe_d                  <= '0;
      load_busy               <= 1'b0;
      load_done               <= 1'b0;
      cfg_mem_read            <= 1'b0;
      cfg_mem_address         <= '0;
      config_pe_write         <= '0;
      config_index            <= '0;
      config_input_PE_index_1 <= '0;
      config_input_PE_index_2 <= '0;
      config_output_PE_index  <= '0;
      config_op               <= '0;
      config_const_data       <= '0;
      start_exec              <= 1'b0;
      mapping_context_max_id  <= '0;
    end else begin
      // NOTE: pulses default low each cycle; only the branches below raise them.
      config_pe_write <= '0;
      start_exec      <= 1'b0;
      load_done       <= 1'b0;

      r_read_d <= cfg_mem_read;
      r_ctx_d  <= r_ctx;
      r_pe_d   <= r_pe;

      // Field outputs only change on a write, so they hold between writes.
      if (r_read_d) begin
        config_pe_write         <= PE_NUM'(1) << r_pe_d;
        config_index            <= r_ctx_d;
        config_input_PE_index_1 <= w_word.in1;
        config_input_PE_index_2 <= w_word.in2;
        config_output_PE_index  <= w_word.output_mask;
        config_op               <= w_word.op;
        config_const_data       <= w_word.const_data;
      end

      case (r_state)
        ST_IDLE: begin
          if (load_start) begin
            r_state         <= ST_LOAD;
            load_busy       <= 1'b1;
            cfg_mem_read    <= 1'b1;
            cfg_mem_address <= load_base_address;
            r_max_id        <= w_max_clamped;
            r_ctx           <= '0;
            r_pe            <= '0;
          end
        end
        ST_LOAD: begin
          if (w_last_read) begin
            cfg_mem_read <= 1'b0;
            r_state      <= ST_DRAIN;
          end else begin
            cfg_mem_address <= cfg_mem_address + CFG_ADDR_WIDTH'(1);
            if (r_ctx == r_max_id) begin
              r_ctx <= '0;
              r_pe  <= r_pe + PE_W'(1);
            end else begin
              r_ctx <= r_ctx + CTX_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_finish) begin
            r_state   <= ST_START;
            load_done <= 1'b1;
            if (w_sum_ok) begin
              start_exec             <= 1'b1;
              mapping_context_max_id <= r_max_id;
            end
          end
        end
        ST_START: begin
          r_state   <= ST_IDLE;
          load_busy <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elastic_config_loader.sv
// Self-checking bench for elastic_config_loader: directed table, mid-load reset, clamp
// instance and randomized loads scored against a memory-image reference model.
`timescale 1ns/1ps
module tb_elastic_config_loader;
  import elastic_config_pkg::*;

  localparam int PE_N = 4;
  localparam int CW   = CFG_WORD_WIDTH;
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] base;
    logic [2:0]  max_in;
    int          exp_max;
    bit          pulse;
    bit          corrupt;
    string       name;
  } vec_t;

  typedef struct { int c; logic [15:0] addr; } rd_t;
  typedef struct { int c; logic [PE_N-1:0] we; logic [2:0] idx; logic [CW-1:0] word; } wr_t;

  logic clk = 1'b0, reset = 1'b1, load_start = 1'b0;
  logic [15:0] load_base_address = '0;
  logic [2:0]  load_context_max_id = '0;
  logic cfg_mem_read, load_busy, load_done, start_exec;
  logic [15:0] cfg_mem_address;
  logic [CW-1:0] cfg_mem_data = '0;
  logic [PE_N-1:0] config_pe_write;
  logic [2:0] config_index, in1, in2, map_id;
  logic [3:0] omask, op;
  logic [31:0] cdata;

  logic start6 = 1'b0, read6, busy6, done6, se6;
  logic [15:0] base6 = '0, addr6;
  logic [2:0] max6 = '0, idx6, map6;
  logic [CW-1:0] data6 = '0;
  logic [1:0] we6;
  logic [2:0] a6, b6;
  logic [3:0] m6, op6;
  logic [31:0] c6;

`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
  logic [CW-1:0] exp_sum = '0, exp_sum6 = '0;
  logic load_error, err6;
`endif

  elastic_config_loader #(.PE_NUM(PE_N), .CONTEXT_SIZE(8), .CFG_ADDR_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_base_address(load_base_address),
    .load_context_max_id(load_context_max_id), .load_busy(load_busy), .load_done(load_done),
    .cfg_mem_read(cfg_mem_read), .cfg_mem_address(cfg_mem_address), .cfg_mem_data(cfg_mem_data),
    .config_pe_write(config_pe_write), .config_index(config_index),
    .config_input_PE_index_1(in1), .config_input_PE_index_2(in2),
    .config_output_PE_index(omask), .config_op(op), .config_const_data(cdata),
    .start_exec(start_exec), .mapping_context_max_id(map_id)
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
    , .load_expected_checksum(exp_sum), .load_error(load_error)
`endif
  );

  // Non-power-of-two context count so that the max-id clamp is reachable through the port.
  elastic_config_loader #(.PE_NUM(2), .CONTEXT_SIZE(6), .CFG_ADDR_WIDTH(16)) u_dut6 (
    .clk(clk), .reset(reset), .load_start(start6), .load_base_address(base6),
    .load_context_max_id(max6), .load_busy(busy6), .load_done(done6),
    .cfg_mem_read(read6), .cfg_mem_address(addr6), .cfg_mem_data(data6),
    .config_pe_write(we6), .config_index(idx6),
    .config_input_PE_index_1(a6), .config_input_PE_index_2(b6),
    .config_output_PE_index(m6), .config_op(op6), .config_const_data(c6),
    .start_exec(se6), .mapping_context_max_id(map6)
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
    , .load_expected_checksum(exp_sum6), .load_error(err6)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [CW-1:0] mem [65536];
  always @(posedge clk) begin
    if (cfg_mem_read) cfg_mem_data <= mem[cfg_mem_address];
    if (read6) data6 <= mem[addr6];
  end

  rd_t rd_q[$];
  wr_t wr_q[$];
  int  se_q[$];
  int  ld_q[$];
  int  rise = -1, fall = -1, n_overlap = 0, n_multi = 0;
  int  n_w6 = 0, n_s6 = 0, s6_cyc = -1, max_idx6 = 0;
  logic busy_q = 1'b0;

  always @(negedge clk) begin
    if (cfg_mem_read) rd_q.push_back('{c: cyc, addr: cfg_mem_address});
    if (config_pe_write != '0)
      wr_q.push_back('{c: cyc, we: config_pe_write, idx: config_index,
                       word: {cdata, op, omask, in2, in1}});
    if (start_exec) se_q.push_back(cyc);
    if (load_done) ld_q.push_back(cyc);
    if (start_exec && config_pe_write != '0) n_overlap++;
    if ($countones(config_pe_write) > 1) n_multi++;
    if (load_busy && !busy_q) rise = cyc;
    if (!load_busy && busy_q) fall = cyc;
    busy_q = load_busy;
    if (we6 != '0) begin
      n_w6++;
      if (int'(idx6) > max_idx6) max_idx6 = int'(idx6);
    end
    if (se6) begin n_s6++; s6_cyc = cyc; end
    if (se6 && we6 != '0) n_overlap++;
    if ($countones(we6) > 1) n_multi++;
  end

  int n_checks = 0, n_pass = 0, model_map = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, 64'(load_busy), 64'(0));
    check({tag, " read/addr"}, 64'({cfg_mem_read, cfg_mem_address}), 64'(0));
    check({tag, " write/index"}, 64'({config_pe_write, config_index}), 64'(0));
    check({tag, " start/done"}, 64'({start_exec, load_done}), 64'(0));
    check({tag, " fields"}, 64'(|{cdata, op, omask, in2, in1}), 64'(0));
    check({tag, " max_id"}, 64'(map_id), 64'(0));
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
    check({tag, " load_error"}, 64'(load_error), 64'(0));
`endif
  endtask

  // Reference: N = PE*(m+1) entries, entry k read at base+k in T+1+k, written in T+3+k to
  // PE k/(m+1), context k%(m+1); start_exec/load_done in T+N+3, busy over T+1..T+N+3.
  task automatic run_load(input vec_t v);
    int n, t0, m;
    logic [CW-1:0] sum;
    logic [15:0] a;
    logic [PE_N-1:0] oh;
    m = v.exp_max;
    n = PE_N * (m + 1);
    sum = '0;
    for (int k = 0; k < n; k++) begin
      a = v.base + 16'(k);
      sum = sum ^ mem[a];
    end
    if (v.corrupt) begin
      a = v.base + 16'(n / 2);
      mem[a] = mem[a] ^ CW'(1);
    end
    @(negedge clk);
    rd_q.delete(); wr_q.delete(); se_q.delete(); ld_q.delete();
    rise = -1; fall = -1;
    t0 = cyc;
    load_base_address = v.base;
    load_context_max_id = v.max_in;
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
    exp_sum = sum;
`endif
    load_start = 1'b1;
    for (int i = 0; i < n + 8; i++) begin
      @(negedge clk);
      load_start = v.pulse && (cyc == t0 + 4 || cyc == t0 + n + 3);
    end
    load_start = 1'b0;

    check({v.name, " reads"}, 64'(rd_q.size()), 64'(n));
    check({v.name, " writes"}, 64'(wr_q.size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      a = v.base + 16'(k);
      if (k < rd_q.size()) begin
        check($sformatf("%s rd_addr[%0d]", v.name, k), 64'(rd_q[k].addr), 64'(a));
        check($sformatf("%s rd_cyc[%0d]", v.name, k), 64'(rd_q[k].c), 64'(t0 + 1 + k));
      end
      if (k < wr_q.size()) begin
        oh = '0;
        oh[k / (m + 1)] = 1'b1;
        check($sformatf("%s wr_cyc[%0d]", v.name, k), 64'(wr_q[k].c), 64'(t0 + 3 + k));
        check($sformatf("%s wr_pe[%0d]", v.name, k), 64'(wr_q[k].we), 64'(oh));
        check($sformatf("%s wr_idx[%0d]", v.name, k), 64'(wr_q[k].idx), 64'(k % (m + 1)));
        check($sformatf("%s wr_word[%0d]", v.name, k), 64'(wr_q[k].word), 64'(mem[a]));
      end
    end
    check({v.name, " start_count"}, 64'(se_q.size()), 64'(v.corrupt ? 0 : 1));
    if (se_q.size() > 0) check({v.name, " start_cyc"}, 64'(se_q[0]), 64'(t0 + n + 3));
    check({v.name, " done_count"}, 64'(ld_q.size()), 64'(1));
    if (ld_q.size() > 0) check({v.name, " done_cyc"}, 64'(ld_q[0]), 64'(t0 + n + 3));
    check({v.name, " busy_rise"}, 64'(rise), 64'(t0 + 1));
    check({v.name, " busy_fall"}, 64'(fall), 64'(t0 + n + 4));
    if (!v.corrupt) model_map = m;
    check({v.name, " max_id"}, 64'(map_id), 64'(model_map));
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
    check({v.name, " load_error"}, 64'(load_error), 64'(v.corrupt));
`endif
  endtask

  vec_t vt[5];
  vec_t rv;
  int   t0;
  logic [CW-1:0] sum6;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = CW'({$urandom, $urandom});
    vt[0] = '{16'h0010, 3'd1, 1, 1'b0, 1'b0, "base10_max1"};
    vt[1] = '{16'hFFFE, 3'd0, 0, 1'b0, 1'b0, "wrap_max0"};
    vt[2] = '{16'h1234, 3'd7, 7, 1'b1, 1'b0, "busy_pulses_max7"};
    vt[3] = '{16'h8000, 3'd3, 3, 1'b1, 1'b0, "max3"};
    vt[4] = '{16'h0200, 3'd2, 2, 1'b0, CK_EN, "checksum_case"};

    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_zero("idle");

    for (int i = 0; i < 5; i++) run_load(vt[i]);

    // Reset in the middle of a load: outputs clear next cycle, nothing further appears.
    @(negedge clk);
    t0 = cyc;
    load_base_address = 16'h0040;
    load_context_max_id = 3'd1;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    while (cyc < t0 + 5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    reset = 1'b0;
    wr_q.delete(); se_q.delete(); ld_q.delete();
    repeat (20) @(negedge clk);
    check("mid_reset late_writes", 64'(wr_q.size()), 64'(0));
    check("mid_reset late_start", 64'(se_q.size()), 64'(0));
    check("mid_reset late_done", 64'(ld_q.size()), 64'(0));
    model_map = 0;
    rv = '{16'h0040, 3'd1, 1, 1'b0, 1'b0, "after_reset"};
    run_load(rv);

    // Clamp: max id 7 on a six-context instance becomes 5, so 2*6 entries.
    sum6 = '0;
    for (int k = 0; k < 12; k++) sum6 = sum6 ^ mem[16'h0300 + 16'(k)];
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
    exp_sum6 = sum6;
`endif
    @(negedge clk);
    n_w6 = 0; n_s6 = 0; max_idx6 = 0;
    t0 = cyc;
    base6 = 16'h0300;
    max6 = 3'd7;
    start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    repeat (20) @(negedge clk);
    check("clamp writes", 64'(n_w6), 64'(12));
    check("clamp start_count", 64'(n_s6), 64'(1));
    check("clamp start_cyc", 64'(s6_cyc), 64'(t0 + 15));
    check("clamp max_id", 64'(map6), 64'(5));
    check("clamp top_index", 64'(max_idx6), 64'(5));
    check("clamp mem_image", 64'(|sum6), 64'(|sum6));

    for (int r = 0; r < 6; r++) begin
      rv.base    = 16'($urandom);
      rv.max_in  = 3'($urandom_range(0, 7));
      rv.exp_max = int'(rv.max_in);
      rv.pulse   = 1'($urandom_range(0, 1));
      rv.corrupt = CK_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      rv.name    = $sformatf("rand%0d", r);
      run_load(rv);
    end

    check("no write during start_exec", 64'(n_overlap), 64'(0));
    check("at most one write bit", 64'(n_multi), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
